// File: rtl/majority_check_pkg.sv
// Shared types and the golden 4-input majority rule for the majority sweep checker.
// Used by the golden model and the sweep sequencer.
package majority_check_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam int NUM_VECTORS = 16;
   localparam int VEC_W       = 4;

   // Strict majority (3 or 4 ones) is 1; an exact 2/2 split returns the tie value.
   function automatic logic maj4_expected(input logic [VEC_W-1:0] vec, input logic tie);
      logic [2:0] ones;
      ones = {2'b00, vec[3]} + {2'b00, vec[2]} + {2'b00, vec[1]} + {2'b00, vec[0]};
      if (ones >= 3'd3) begin
         return 1'b1;
      end else if (ones == 3'd2) begin
         return tie;
      end else begin
         return 1'b0;
      end
   endfunction

endpackage

// File: rtl/majority_golden.sv
// Combinational golden model of the 4-input majority cell.
// Reusable by any checker that needs the expected output for a vector.
module majority_golden
   import majority_check_pkg::*;
(
   input  logic [VEC_W-1:0] vec,
   input  logic             tie,
   output logic             expected
);

   assign expected = maj4_expected(vec, tie);

endmodule

// File: rtl/majority_sweep_checker.sv
// Drives all 16 vectors into a majority cell, samples y_in after a settle time,
// and accumulates a saturating mismatch count plus the first failing vector.
module majority_sweep_checker
   import majority_check_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter logic        TIE_VALUE     = 1'b0,
   parameter int unsigned ERR_W         = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             a,
   output logic             b,
   output logic             c,
   output logic             d,
   input  logic             y_in,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic             first_err_valid,
   output logic [3:0]       first_err_vec,
   output logic [1:0]       state_dbg
);

   localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
   localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};
   localparam logic [VEC_W-1:0] LAST_VEC    = 4'(NUM_VECTORS - 1);

   state_t           state, state_nxt;
   logic [VEC_W-1:0] vec, vec_nxt;
   logic [3:0]       settle_cnt, settle_cnt_nxt;
   logic [ERR_W-1:0] err_cnt_r, err_cnt_nxt;
   logic             first_valid_r, first_valid_nxt;
   logic [VEC_W-1:0] first_vec_r, first_vec_nxt;
   logic             expected;
   logic             mismatch;
   logic             driving;

   majority_golden u_golden (
      .vec      (vec),
      .tie      (TIE_VALUE),
      .expected (expected)
   );

   assign mismatch = (y_in != expected);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         vec           <= '0;
         settle_cnt    <= '0;
         err_cnt_r     <= '0;
         first_valid_r <= 1'b0;
         first_vec_r   <= '0;
      end else begin
         state         <= state_nxt;
         vec           <= vec_nxt;
         settle_cnt    <= settle_cnt_nxt;
         err_cnt_r     <= err_cnt_nxt;
         first_valid_r <= first_valid_nxt;
         first_vec_r   <= first_vec_nxt;
      end
   end

   // Protocol: start is a level request honoured only in IDLE or DONE; busy is high
   // for every DRIVE/SAMPLE cycle, and done holds the result until the next start.
   always_comb begin
      state_nxt       = state;
      vec_nxt         = vec;
      settle_cnt_nxt  = settle_cnt;
      err_cnt_nxt     = err_cnt_r;
      first_valid_nxt = first_valid_r;
      first_vec_nxt   = first_vec_r;
      unique case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nxt       = DRIVE;
               vec_nxt         = '0;
               settle_cnt_nxt  = '0;
               err_cnt_nxt     = '0;
               first_valid_nxt = 1'b0;
               first_vec_nxt   = '0;
            end
         end
         DRIVE: begin
            if (settle_cnt == SETTLE_LAST) begin
               state_nxt      = SAMPLE;
               settle_cnt_nxt = '0;
            end else begin
               settle_cnt_nxt = settle_cnt + 4'd1;
            end
         end
         SAMPLE: begin
            if (mismatch) begin
               if (err_cnt_r != ERR_MAX) begin
                  err_cnt_nxt = err_cnt_r + 1'b1;
               end
               if (!first_valid_r) begin
                  first_valid_nxt = 1'b1;
                  first_vec_nxt   = vec;
               end
            end
            // Vector 15 is terminal; the index never wraps inside a sweep.
            if (vec == LAST_VEC) begin
               state_nxt = DONE;
            end else begin
               vec_nxt        = vec + 4'd1;
               settle_cnt_nxt = '0;
               state_nxt      = DRIVE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign driving         = (state == DRIVE) || (state == SAMPLE);
   assign {a, b, c, d}    = driving ? vec : 4'b0000;
   assign busy            = driving;
   assign done            = (state == DONE);
   assign pass            = done && (err_cnt_r == '0);
   assign err_count       = err_cnt_r;
   assign first_err_valid = first_valid_r;
   assign first_err_vec   = first_vec_r;
   assign state_dbg       = state;

endmodule

// File: tb/tb_majority_sweep_checker.sv
// Bench for majority_sweep_checker: a behavioural majority cell with selectable
// faults feeds y_in; sweep results are compared to tables and a reference model.
module tb_majority_sweep_checker;

   localparam int SETTLE    = 2;
   localparam int BUSY_LEN  = 16 * (SETTLE + 1);
   localparam int SETTLE3   = 1;
   localparam int ERR_W3    = 3;
   localparam int M_IDEAL   = 0;
   localparam int M_STUCK1  = 1;
   localparam int M_TIES1   = 2;
   localparam int M_INVERT  = 3;
   localparam int M_MASK    = 4;

   // clock / reset
   logic clk = 1'b0;
   logic rst_n;
   logic start;
   always #5 clk = ~clk;

   logic       a, b, c, d, y_in, busy, done, pass, first_err_valid;
   logic [4:0] err_count;
   logic [3:0] first_err_vec;
   logic [1:0] state_dbg;

   logic       a3, b3, c3, d3, y_in3, busy3, done3, pass3, first_err_valid3;
   logic [2:0] err_count3;
   logic [3:0] first_err_vec3;
   logic [1:0] state_dbg3;

   int          mode, mode3;
   logic [15:0] mask, mask3;
   int          errors = 0;
   int          checks = 0;
   logic [3:0]  exp_q[$];

   majority_sweep_checker #(.SETTLE_CYCLES(SETTLE), .TIE_VALUE(1'b0), .ERR_W(5)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .a(a), .b(b), .c(c), .d(d), .y_in(y_in),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count),
      .first_err_valid(first_err_valid), .first_err_vec(first_err_vec), .state_dbg(state_dbg)
   );

   majority_sweep_checker #(.SETTLE_CYCLES(SETTLE3), .TIE_VALUE(1'b0), .ERR_W(ERR_W3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .start(start),
      .a(a3), .b(b3), .c(c3), .d(d3), .y_in(y_in3),
      .busy(busy3), .done(done3), .pass(pass3), .err_count(err_count3),
      .first_err_valid(first_err_valid3), .first_err_vec(first_err_vec3), .state_dbg(state_dbg3)
   );

   // reference model
   function automatic logic golden(input logic [3:0] v, input logic tie);
      int ones;
      ones = $countones(v);
      if (ones >= 3) return 1'b1;
      if (ones == 2) return tie;
      return 1'b0;
   endfunction

   function automatic logic cell_y(input logic [3:0] v, input int m, input logic [15:0] msk);
      case (m)
         M_STUCK1: return 1'b1;
         M_TIES1:  return ($countones(v) >= 2);
         M_INVERT: return !golden(v, 1'b0);
         M_MASK:   return golden(v, 1'b0) ^ msk[v];
         default:  return golden(v, 1'b0);
      endcase
   endfunction

   always_comb y_in  = cell_y({a, b, c, d}, mode, mask);
   always_comb y_in3 = cell_y({a3, b3, c3, d3}, mode3, mask3);

   task automatic ref_sweep(input int m, input logic [15:0] msk, input int errw,
                            output int exp_err, output logic exp_fv, output logic [3:0] exp_fvec);
      int sat;
      sat      = (1 << errw) - 1;
      exp_err  = 0;
      exp_fv   = 1'b0;
      exp_fvec = 4'd0;
      for (int v = 0; v < 16; v++) begin
         if (cell_y(4'(v), m, msk) != golden(4'(v), 1'b0)) begin
            if (!exp_fv) begin
               exp_fv   = 1'b1;
               exp_fvec = 4'(v);
            end
            exp_err++;
         end
      end
      if (exp_err > sat) exp_err = sat;
   endtask

   // scoreboard
   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, " abcd"}, 32'({a, b, c, d}), 32'd0);
      check({tag, " busy"}, 32'(busy), 32'd0);
      check({tag, " done"}, 32'(done), 32'd0);
      check({tag, " pass"}, 32'(pass), 32'd0);
      check({tag, " err_count"}, 32'(err_count), 32'd0);
      check({tag, " first_err_valid"}, 32'(first_err_valid), 32'd0);
      check({tag, " first_err_vec"}, 32'(first_err_vec), 32'd0);
      check({tag, " state"}, 32'(state_dbg), 32'd0);
   endtask

   task automatic check_result(input string tag, input int exp_err, input logic exp_fv,
                               input logic [3:0] exp_fvec, input logic exp_pass);
      check({tag, " done"}, 32'(done), 32'd1);
      check({tag, " busy idle"}, 32'(busy), 32'd0);
      check({tag, " abcd idle"}, 32'({a, b, c, d}), 32'd0);
      check({tag, " err_count"}, 32'(err_count), 32'(exp_err));
      check({tag, " first_err_valid"}, 32'(first_err_valid), 32'(exp_fv));
      check({tag, " first_err_vec"}, 32'(first_err_vec), 32'(exp_fvec));
      check({tag, " pass"}, 32'(pass), 32'(exp_pass));
   endtask

   task automatic check_result3(input string tag, input int exp_err, input logic exp_fv,
                                input logic [3:0] exp_fvec);
      check({tag, " w3 done"}, 32'(done3), 32'd1);
      check({tag, " w3 err_count"}, 32'(err_count3), 32'(exp_err));
      check({tag, " w3 first_err_valid"}, 32'(first_err_valid3), 32'(exp_fv));
      check({tag, " w3 first_err_vec"}, 32'(first_err_vec3), 32'(exp_fvec));
      check({tag, " w3 pass"}, 32'(pass3), 32'(exp_err == 0));
   endtask

   // driver: called at a negedge with the DUT in IDLE or DONE
   task automatic run_sweep(input string tag, input bit hold_start);
      int busy_cycles;
      bit timed_out;
      exp_q.delete();
      for (int v = 0; v < 16; v++)
         for (int k = 0; k <= SETTLE; k++) exp_q.push_back(4'(v));
      start = 1'b1;
      @(negedge clk);
      if (!hold_start) start = 1'b0;
      busy_cycles = 0;
      timed_out   = 1'b1;
      for (int cyc = 0; cyc < BUSY_LEN + 20; cyc++) begin
         if (done) begin
            timed_out = 1'b0;
            break;
         end
         if (busy) begin
            busy_cycles++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL %s vec overrun: got %0d busy cycles required %0d", tag, busy_cycles, BUSY_LEN);
            end else begin
               check({tag, " vec order"}, 32'({a, b, c, d}), 32'(exp_q.pop_front()));
            end
         end
         @(negedge clk);
      end
      check({tag, " done timeout"}, 32'(timed_out), 32'd0);
      check({tag, " busy cycles"}, 32'(busy_cycles), 32'(BUSY_LEN));
   endtask

   typedef struct {
      string       name;
      int          mode;
      int          exp_err;
      logic        exp_fv;
      logic [3:0]  exp_fvec;
      logic        exp_pass;
   } vec_rec_t;

   vec_rec_t tbl[4];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int         e_err, e_err3;
      logic       e_fv, e_fv3;
      logic [3:0] e_fvec, e_fvec3;
      bit         reached;

      tbl[0] = '{"ideal",  M_IDEAL,   0, 1'b0, 4'b0000, 1'b1};
      tbl[1] = '{"stuck1", M_STUCK1, 11, 1'b1, 4'b0000, 1'b0};
      tbl[2] = '{"ties1",  M_TIES1,   6, 1'b1, 4'b0011, 1'b0};
      tbl[3] = '{"invert", M_INVERT, 16, 1'b1, 4'b0000, 1'b0};

      rst_n = 1'b0;
      start = 1'b0;
      mode  = M_IDEAL;
      mode3 = M_INVERT;
      mask  = '0;
      mask3 = '0;
      repeat (3) @(negedge clk);
      check_reset("reset");
      rst_n = 1'b1;
      @(negedge clk);
      check("idle ignores absent start", 32'(state_dbg), 32'd0);

      // table-driven sweeps; narrow checker sees an inverted cell every time
      for (int i = 0; i < 4; i++) begin
         mode = tbl[i].mode;
         run_sweep(tbl[i].name, 1'b0);
         check_result(tbl[i].name, tbl[i].exp_err, tbl[i].exp_fv, tbl[i].exp_fvec, tbl[i].exp_pass);
         check_result3(tbl[i].name, 7, 1'b1, 4'b0000);
         @(negedge clk);
         check({tbl[i].name, " done holds"}, 32'(done), 32'd1);
      end

      // random fault masks against the reference model
      for (int r = 0; r < 6; r++) begin
         mode  = M_MASK;
         mode3 = M_MASK;
         mask  = 16'($urandom_range(0, 16'hFFFF));
         mask3 = 16'($urandom_range(0, 16'hFFFF));
         if (r == 0) mask = 16'h8000;
         ref_sweep(M_MASK, mask, 5, e_err, e_fv, e_fvec);
         ref_sweep(M_MASK, mask3, ERR_W3, e_err3, e_fv3, e_fvec3);
         run_sweep("random", 1'b0);
         check_result("random", e_err, e_fv, e_fvec, e_err == 0);
         check_result3("random", e_err3, e_fv3, e_fvec3);
      end
      mode3 = M_INVERT;

      // reset asserted while vector 7 is on the bus
      mode  = M_STUCK1;
      start = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      reached = 1'b0;
      for (int cyc = 0; cyc < 100; cyc++) begin
         if (busy && ({a, b, c, d} == 4'd7)) begin
            reached = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("midreset reached vec7", 32'(reached), 32'd1);
      check("midreset errs before", 32'(err_count), 32'd7);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset("midreset");
      @(negedge clk);
      check_reset("midreset held");
      rst_n = 1'b1;
      @(negedge clk);
      mode = M_IDEAL;
      run_sweep("after reset", 1'b0);
      check_result("after reset", 0, 1'b0, 4'b0000, 1'b1);

      // start held high: one sweep, one done cycle, cleared restart
      mode = M_STUCK1;
      run_sweep("held start", 1'b1);
      check_result("held start", 11, 1'b1, 4'b0000, 1'b0);
      @(negedge clk);
      check("restart done low", 32'(done), 32'd0);
      check("restart busy", 32'(busy), 32'd1);
      check("restart err cleared", 32'(err_count), 32'd0);
      check("restart first cleared", 32'(first_err_valid), 32'd0);
      check("restart vec0", 32'({a, b, c, d}), 32'd0);
      start   = 1'b0;
      reached = 1'b0;
      for (int cyc = 0; cyc < BUSY_LEN + 20; cyc++) begin
         if (done) begin
            reached = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("restart done reached", 32'(reached), 32'd1);
      check_result("restart", 11, 1'b1, 4'b0000, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/majority_sweep_checker.md
Name: majority_sweep_checker

Overview:
- Self-checking sequential consumer for the 4-input majority primitive.
- Sweeps all 16 input vectors into the device under check, waits a programmable settle time, samples y, and compares it against a golden majority function.
- Reports error count, first failing vector and pass/fail.
- Hardware counterpart to the simulation stimulus bench: used on-chip/FPGA as the vector source and result checker around the majority cell.

Parameters:
- SETTLE_CYCLES, 2, clocks each vector is held before y is sampled; legal range 1..15.
- TIE_VALUE, 0, golden output when exactly two inputs are 1.
- ERR_W, 5, width of error counter; saturates at 2^ERR_W-1.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request sweep; sampled in IDLE or DONE, ignored while busy
- a  output  1  vector bit 3 (MSB) to DUT
- b  output  1  vector bit 2 to DUT
- c  output  1  vector bit 1 to DUT
- d  output  1  vector bit 0 (LSB) to DUT
- y_in  input  1  DUT majority output
- busy  output  1  high throughout a sweep
- done  output  1  level; high in DONE until next start or reset
- pass  output  1  valid when done; 1 iff err_count==0
- err_count  output  ERR_W  mismatches in current/last sweep, saturating
- first_err_valid  output  1  a mismatch has been recorded this sweep
- first_err_vec  output  4  {a,b,c,d} of first mismatch

Behaviour:
- Reset (async, rst_n=0): state IDLE; a,b,c,d=0; busy=0; done=0; pass=0; err_count=0; first_err_valid=0; first_err_vec=0; vector index=0; settle counter=0.
- Golden model: ones = a+b+c+d (3-bit). Expected y = 1 if ones>=3; TIE_VALUE if ones==2; 0 if ones<=1.
- States:
  - IDLE: outputs hold 0000. start=1 -> clear err_count, first_err_*, pass; vec=0; settle cnt=0; go to DRIVE.
  - DRIVE: {a,b,c,d}=vec. Settle counter increments each cycle; after SETTLE_CYCLES cycles in DRIVE, go to SAMPLE.
  - SAMPLE: one cycle, vector still driven. Compare y_in to expected.
    - On mismatch: err_count+1, saturating. If first_err_valid==0, latch first_err_vec=vec and set first_err_valid.
    - If vec==15, go to DONE. Otherwise vec+1, settle cnt=0, go to DRIVE.
  - DONE: done=1; pass=(err_count==0); outputs return to 0000. start=1 -> same as IDLE start (done, pass and counters cleared on the transition cycle).
- busy=1 exactly in DRIVE and SAMPLE.
- Latency: start sampled at edge N -> busy=1 after edge N. Sweep occupies 16*(SETTLE_CYCLES+1) cycles; done=1 after the final SAMPLE edge. Default: 48 busy cycles.
- Vector order: ascending 0000..1111, a = MSB. Each vector is held SETTLE_CYCLES+1 cycles.
- start while busy: no effect, no queuing.
- Reset mid-sweep: immediate abort to the reset values above; no partial results retained.
- Vector index wrap: never wraps within a sweep. 15 is terminal.
- err_count saturation: with ERR_W=5, counting stops at 31. Max real errors = 16, so saturation only matters for ERR_W<=4.
- y_in is treated as synchronous to clk; no synchronizer inside.

Decomposition:
- Package majority_check_pkg:
  - state enum (IDLE, DRIVE, SAMPLE, DONE)
  - NUM_VECTORS=16, VEC_W=4
  - function maj4_expected(vec, tie)
- Sub-module majority_golden: combinational golden model, 4-bit vector + TIE_VALUE -> expected bit. Instantiated once; reusable by other checkers.

Test Plan:
- Correct DUT (ideal 3-of-4 majority, ties->0), SETTLE_CYCLES=2, start pulse -> busy high 48 cycles; done=1, pass=1, err_count=0, first_err_valid=0.
- DUT stuck-at-1 on y -> err_count=11 (vectors with <=2 ones), first_err_vec=0000, pass=0.
- DUT with ties->1 while TIE_VALUE=0 -> err_count=6, first_err_vec=0011, pass=0.
- Assert rst_n=0 at vector 7 mid-sweep -> all outputs to reset values same cycle. After release, start -> full clean sweep, pass=1.
- start held high continuously -> one sweep, done for 1 cycle, then immediate restart. Counters cleared on restart; no start effect while busy.
- ERR_W=3, DUT y inverted -> err_count saturates at 7, first_err_vec=0000, pass=0.
